// File: rtl/axim_rd_ctrl.sv
// AXI4 read master: splits a byte-sized transfer into 4 KB-safe INCR bursts, one outstanding, streamed out with no buffering.
// R data passes straight through in DATA (zero latency, rready follows rd_tready_i); rdone pulses two cycles after the final accept.
module axim_rd_ctrl #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_MAX_BURST_LEN    = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ctrl_rstart_i,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_raddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_rxfer_size_i,
  output logic                          ctrl_rdone_o,
  output logic                          ctrl_rbusy_o,
  output logic                          ctrl_rerr_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_tdata_o,
  output logic                          rd_tvalid_o,
  input  logic                          rd_tready_i,
  output logic                          rd_tlast_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int RW = C_XFER_SIZE_WIDTH + 1;
  localparam int CW = (RW > 12) ? RW : 12;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [RW-1:0]                 r_remaining;
  logic [8:0]                    r_beats;
  logic [8:0]                    r_cnt;
  logic                          r_err;
  logic                          r_done;

  logic [CW-1:0] w_rem_ext;
  logic [CW-1:0] w_bnd;
  logic [CW-1:0] w_beats;
  logic [RW-1:0] w_words;
  logic [RW-1:0] w_rem_after;
  logic          w_start;
  logic          w_beat;
  logic          w_burst_end;
  logic          w_unused;

  // Burst length: smallest of the max burst, words left, and words to the next 4 KB page.
  always_comb begin
    w_rem_ext = CW'(r_remaining);
    w_bnd     = CW'(11'd1024 - {1'b0, r_addr[11:2]});
    w_beats   = CW'(C_MAX_BURST_LEN);
    if (w_rem_ext < w_beats) w_beats = w_rem_ext;
    if (w_bnd < w_beats)     w_beats = w_bnd;
  end

  assign w_words     = (RW'(ctrl_rxfer_size_i) + RW'(3)) >> 2;
  assign w_start     = (r_state == S_IDLE) && ctrl_rstart_i;
  assign w_beat      = (r_state == S_DATA) && m_axi_rvalid && rd_tready_i;
  assign w_burst_end = w_beat && (r_cnt == r_beats - 9'd1);
  assign w_rem_after = r_remaining - RW'(r_beats);

  // rlast is informational only; the beat counter decides where a burst ends.
  assign w_unused = ^{m_axi_rlast, m_axi_rresp[0], w_beats[CW-1:9]};

  always_comb begin
    w_next        = r_state;
    m_axi_arvalid = 1'b0;
    m_axi_arlen   = 8'd0;
    m_axi_rready  = 1'b0;
    rd_tvalid_o   = 1'b0;
    rd_tlast_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ctrl_rstart_i) w_next = (w_words == '0) ? S_DONE : S_ADDR;
      end
      S_ADDR: begin
        m_axi_arvalid = 1'b1;
        m_axi_arlen   = w_beats[7:0] - 8'd1;
        if (m_axi_arready) w_next = S_DATA;
      end
      S_DATA: begin
        m_axi_rready = rd_tready_i;
        rd_tvalid_o  = m_axi_rvalid;
        rd_tlast_o   = m_axi_rvalid && ((r_remaining - RW'(r_cnt)) == RW'(1));
        if (w_burst_end) w_next = (w_rem_after == '0) ? S_DONE : S_ADDR;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      if (w_start) begin
        r_addr      <= ctrl_raddr_offset_i;
        r_remaining <= w_words;
        r_cnt       <= '0;
        r_err       <= 1'b0;
      end
      if ((r_state == S_ADDR) && m_axi_arready) begin
        r_beats <= w_beats[8:0];
        r_cnt   <= '0;
      end
      if (w_beat) begin
        if (m_axi_rresp[1]) r_err <= 1'b1;
        if (w_burst_end) begin
          r_cnt       <= '0;
          r_addr      <= r_addr + C_M_AXI_ADDR_WIDTH'({r_beats, 2'b00});
          r_remaining <= w_rem_after;
        end else begin
          r_cnt <= r_cnt + 9'd1;
        end
      end
    end
  end

  assign m_axi_araddr  = r_addr;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign rd_tdata_o    = m_axi_rdata;
  assign ctrl_rbusy_o  = (r_state != S_IDLE);
  assign ctrl_rdone_o  = r_done;
  assign ctrl_rerr_o   = r_err;

endmodule

// File: tb/tb_axim_rd_ctrl.sv
// Bench for axim_rd_ctrl: a reactive AXI slave plus a transfer-level reference model, checked every cycle.
module tb_axim_rd_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ctrl_rstart_i;
  logic [31:0] ctrl_raddr_offset_i;
  logic [31:0] ctrl_rxfer_size_i;
  logic        ctrl_rdone_o, ctrl_rbusy_o, ctrl_rerr_o;
  logic [31:0] rd_tdata_o;
  logic        rd_tvalid_o, rd_tready_i, rd_tlast_o;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  axim_rd_ctrl dut (
    .clk(clk), .rstn(rstn),
    .ctrl_rstart_i(ctrl_rstart_i), .ctrl_raddr_offset_i(ctrl_raddr_offset_i),
    .ctrl_rxfer_size_i(ctrl_rxfer_size_i), .ctrl_rdone_o(ctrl_rdone_o),
    .ctrl_rbusy_o(ctrl_rbusy_o), .ctrl_rerr_o(ctrl_rerr_o),
    .rd_tdata_o(rd_tdata_o), .rd_tvalid_o(rd_tvalid_o), .rd_tready_i(rd_tready_i),
    .rd_tlast_o(rd_tlast_o),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int          tests = 0;
  int          fails = 0;
  logic        exp_err;
  int          obs_ar_n, obs_beats, obs_tlast_cnt, obs_tlast_idx, obs_done_cnt, obs_done_iter;
  logic        obs_err_at_done;
  logic [31:0] obs_ar_addr [64];
  logic [7:0]  obs_ar_len  [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fdat(input logic [31:0] a, input logic [31:0] salt);
    return {a[15:0], a[31:16]} ^ salt;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_rready"},  m_axi_rready, 0);
    chk({tag, "_tvalid"},  rd_tvalid_o, 0);
    chk({tag, "_tlast"},   rd_tlast_o, 0);
    chk({tag, "_rdone"},   ctrl_rdone_o, 0);
    chk({tag, "_rbusy"},   ctrl_rbusy_o, 0);
    chk({tag, "_rerr"},    ctrl_rerr_o, 0);
    chk({tag, "_araddr"},  m_axi_araddr, 0);
    chk({tag, "_arlen"},   m_axi_arlen, 0);
  endtask

  // One transfer: the model plans the ARs and data, the slave follows the DUT's own AR fields.
  task automatic run_xfer(input logic [31:0] addr, input int size, input bit rnd,
                          input int err_beat, input int extra_start, input int rst_beat);
    logic [31:0] eq_addr[$];
    logic [7:0]  eq_len[$];
    logic [31:0] a, baddr, salt, prev_addr;
    logic [7:0]  prev_len;
    int          words, rem, b, bnd, gbeat, left, due;
    bit          active, rv_hold, prev_pend, exp_tv;

    salt  = $urandom;
    words = (size + 3) / 4;
    a     = addr;
    rem   = words;
    while (rem > 0) begin
      bnd = (4096 - int'(a[11:0])) / 4;
      b   = (rem < 16) ? rem : 16;
      if (bnd < b) b = bnd;
      eq_addr.push_back(a);
      eq_len.push_back(8'(b - 1));
      a   = a + 32'(4 * b);
      rem = rem - b;
    end
    obs_ar_n = 0; obs_beats = 0; obs_tlast_cnt = 0; obs_tlast_idx = -1;
    obs_done_cnt = 0; obs_done_iter = -1; obs_err_at_done = 1'b0;
    active = 0; rv_hold = 0; prev_pend = 0; gbeat = 0; left = 0; due = -1;
    baddr = '0; prev_addr = '0; prev_len = '0;

    for (int it = 0; it < 4000; it++) begin
      @(negedge clk);
      ctrl_rstart_i = (it == 0) || (it == extra_start && (due < 0 || it < due));
      if (it == 0) begin
        ctrl_raddr_offset_i = addr;
        ctrl_rxfer_size_i   = 32'(size);
      end else begin
        ctrl_raddr_offset_i = $urandom & 32'hFFFF_FFFC;
        ctrl_rxfer_size_i   = $urandom_range(4, 64);
      end
      m_axi_arready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      rd_tready_i   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (active) begin
        if (!rv_hold) m_axi_rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        m_axi_rdata = fdat(baddr, salt);
        m_axi_rresp = (gbeat == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast = (left == 1);
      end else begin
        m_axi_rvalid = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
        m_axi_rdata  = $urandom;
        m_axi_rresp  = 2'b11;
        m_axi_rlast  = 1'($urandom_range(0, 1));
      end
      if (rst_beat >= 0 && active && gbeat == rst_beat && m_axi_rvalid) begin
        rstn = 1'b0;
        #1;
        chk_quiet("midrst");
        exp_err       = 1'b0;
        m_axi_rvalid  = 1'b0;
        ctrl_rstart_i = 1'b0;
        return;
      end
      #1;
      exp_tv = active && m_axi_rvalid;
      chk("tvalid", rd_tvalid_o, exp_tv);
      chk("rready", m_axi_rready, active && rd_tready_i);
      chk("tlast", rd_tlast_o, exp_tv && (gbeat == words - 1));
      if (exp_tv) chk("tdata", rd_tdata_o, fdat(addr + 32'(4 * gbeat), salt));
      chk("rdone", ctrl_rdone_o, it == due);
      if (it > 0) chk("rbusy", ctrl_rbusy_o, due < 0 || it < due);
      chk("rerr", ctrl_rerr_o, exp_err);
      if (active) chk("ar_outstanding", m_axi_arvalid, 0);
      if (prev_pend) begin
        chk("ar_hold_valid", m_axi_arvalid, 1);
        chk("ar_hold_addr", m_axi_araddr, prev_addr);
        chk("ar_hold_len", m_axi_arlen, prev_len);
      end
      if (ctrl_rdone_o) begin
        obs_done_cnt++;
        obs_done_iter   = it;
        obs_err_at_done = ctrl_rerr_o;
      end
      if (it == 0) begin
        exp_err = 1'b0;
        if (words == 0) due = 2;
      end
      if (active && m_axi_rvalid && rd_tready_i) begin
        if (rd_tlast_o) begin
          obs_tlast_cnt++;
          obs_tlast_idx = gbeat;
        end
        if (m_axi_rresp[1]) exp_err = 1'b1;
        gbeat++; obs_beats++; left--; rv_hold = 0;
        baddr = baddr + 32'd4;
        if (left == 0) begin
          active = 0;
          if (gbeat >= words) due = it + 2;
        end
      end else begin
        rv_hold = active && m_axi_rvalid;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        if (eq_addr.size() == 0) begin
          chk("ar_extra", m_axi_arvalid, 0);
        end else begin
          chk("araddr", m_axi_araddr, eq_addr.pop_front());
          chk("arlen", m_axi_arlen, eq_len.pop_front());
          chk("arsize", m_axi_arsize, 3'b010);
          chk("arburst", m_axi_arburst, 2'b01);
        end
        if (obs_ar_n < 64) begin
          obs_ar_addr[obs_ar_n] = m_axi_araddr;
          obs_ar_len[obs_ar_n]  = m_axi_arlen;
        end
        obs_ar_n++;
        active = 1;
        left   = int'(m_axi_arlen) + 1;
        baddr  = m_axi_araddr;
      end
      prev_pend = m_axi_arvalid && !m_axi_arready;
      prev_addr = m_axi_araddr;
      prev_len  = m_axi_arlen;
      if (due >= 0 && it >= due + 3) break;
    end
    chk("done_count", obs_done_cnt, 1);
    chk("beat_count", obs_beats, words);
    chk("ar_missing", eq_addr.size(), 0);
    ctrl_rstart_i = 1'b0;
    m_axi_rvalid  = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; exp_err = 1'b0;
    ctrl_rstart_i = 0; ctrl_raddr_offset_i = '0; ctrl_rxfer_size_i = '0;
    rd_tready_i = 0; m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 0; m_axi_rvalid = 0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #2 rstn = 1'b1;

    run_xfer(32'h4000_0000, 256, 0, -1, -1, -1);
    chk("t256_ars", obs_ar_n, 4);
    chk("t256_ar0", obs_ar_addr[0], 32'h4000_0000);
    chk("t256_ar1", obs_ar_addr[1], 32'h4000_0040);
    chk("t256_ar2", obs_ar_addr[2], 32'h4000_0080);
    chk("t256_ar3", obs_ar_addr[3], 32'h4000_00C0);
    chk("t256_len0", obs_ar_len[0], 8'd15);
    chk("t256_len3", obs_ar_len[3], 8'd15);
    chk("t256_beats", obs_beats, 64);
    chk("t256_tlast_cnt", obs_tlast_cnt, 1);
    chk("t256_tlast_idx", obs_tlast_idx, 63);
    chk("t256_err", obs_err_at_done, 0);

    run_xfer(32'h4000_0FF0, 64, 1, -1, -1, -1);
    chk("t4k_ars", obs_ar_n, 2);
    chk("t4k_ar0", obs_ar_addr[0], 32'h4000_0FF0);
    chk("t4k_len0", obs_ar_len[0], 8'd3);
    chk("t4k_ar1", obs_ar_addr[1], 32'h4000_1000);
    chk("t4k_len1", obs_ar_len[1], 8'd11);
    chk("t4k_beats", obs_beats, 16);

    run_xfer(32'h2000_0100, 6, 1, -1, -1, -1);
    chk("t6_ars", obs_ar_n, 1);
    chk("t6_len", obs_ar_len[0], 8'd1);
    chk("t6_tlast_idx", obs_tlast_idx, 1);

    run_xfer(32'h1234_5678, 0, 0, -1, 1, -1);
    chk("t0_ars", obs_ar_n, 0);
    chk("t0_done_iter", obs_done_iter, 2);
    chk("t0_done_cnt", obs_done_cnt, 1);

    run_xfer(32'h3000_0000, 128, 1, -1, 6, -1);
    chk("tbusy_start_beats", obs_beats, 32);

    run_xfer(32'h5000_0000, 64, 1, 4, -1, -1);
    chk("terr_beats", obs_beats, 16);
    chk("terr_at_done", obs_err_at_done, 1);
    run_xfer(32'h5000_1000, 32, 0, -1, -1, -1);
    chk("terr_cleared", obs_err_at_done, 0);

    run_xfer(32'hFFFF_FFF0, 32, 1, -1, -1, -1);
    chk("twrap_ar1", obs_ar_addr[1], 32'h0000_0000);
    chk("twrap_len0", obs_ar_len[0], 8'd3);

    run_xfer(32'h6000_0000, 256, 0, 0, -1, 2);
    chk("trst_no_done", obs_done_cnt, 0);
    repeat (2) begin
      @(negedge clk);
      chk_quiet("in_reset");
    end
    @(posedge clk); #2 rstn = 1'b1;
    run_xfer(32'h6000_0000, 16, 1, -1, -1, -1);
    chk("tpost_rst_beats", obs_beats, 4);
    chk("tpost_rst_err", obs_err_at_done, 0);

    for (int n = 0; n < 12; n++) begin
      logic [31:0] ra;
      ra = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hF00 | (12'($urandom_range(0, 63)) << 2);
      run_xfer(ra, $urandom_range(0, 400), 1,
               ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
